sd_sector_cache: RTL and testbench
==================================

Name: sd_sector_cache

Overview:
- Single-sector write-back cache between a core's byte-addressed disk/image controller and the SD block interface of the MiST I/O block (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*).
- Turns byte reads and writes into 512-byte sector fills and flushes over the ARM-driven SD handshake.
- Holds one 512x8 sector buffer, with a valid flag, a dirty flag and the cached LBA.

Parameters:
- none; sector size fixed at 512 bytes, addresses 32 bits.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
img_mounted  in  1  one-cycle pulse: new image mounted
img_size  in  32  image size in bytes
rd_req  in  1  byte read request, one-cycle pulse
wr_req  in  1  byte write request, one-cycle pulse
flush_req  in  1  write back dirty sector, one-cycle pulse
byte_addr  in  32  byte address, sampled with request
wr_data  in  8  write byte, sampled with wr_req
rd_data  out  8  read result, valid when done=1
busy  out  1  1 from request acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  qualifies done: out-of-range / no image / aborted
sd_lba  out  32  sector number to I/O block
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
sd_ack  in  1  transfer in progress
sd_buff_addr  in  9  buffer byte index from I/O block
sd_buff_dout  in  8  incoming sector byte
sd_buff_wr  in  1  incoming byte strobe
sd_buff_din  out  8  outgoing sector byte

Behaviour:
- Clocking and reset:
  - One clock, clk_sys; reset is synchronous and active-high.
  - Reset forces state IDLE and clears valid, dirty, mounted and mount_pend.
  - Outputs on reset: rd_data=0, busy=0, done=0, err=0, sd_lba=0, sd_rd=0, sd_wr=0, sd_buff_din=0.
  - Buffer contents are not reset.
- Request acceptance:
  - Requests are accepted only in IDLE; requests arriving while busy=1 are dropped.
  - Priority for simultaneous requests: wr_req > rd_req > flush_req.
  - busy goes high the cycle after acceptance.
- mounted flag: set by img_mounted, cleared only by reset.
- LOOKUP state:
  - Compute lba = {9'b0, byte_addr[31:9]} and off = byte_addr[8:0].
  - Error path: if mounted=0 or byte_addr >= img_size (unsigned), go to DONE with err=1 and rd_data=8'hFF.
  - Hit (valid && lba==cached_lba) goes to HIT.
  - Miss with dirty=1 goes to FLUSH_REQ; miss with dirty=0 goes to FILL_REQ.
- HIT state:
  - Read: rd_data <= buf[off].
  - Write: buf[off] <= wr_data, dirty <= 1.
  - Next state is DONE.
  - Hit latency: request in cycle N → done=1 in cycle N+3.
- FLUSH_REQ:
  - sd_lba = cached_lba, sd_wr = 1.
  - Hold until sd_ack=1, then drop sd_wr and go to FLUSH_XFER.
- FLUSH_XFER:
  - Every cycle, sd_buff_din <= buf[sd_buff_addr] (1-cycle registered read).
  - sd_buff_wr is ignored in this state.
  - On sd_ack=0: dirty <= 0, then go to FILL_REQ (or to DONE if this is a flush_req).
- FILL_REQ:
  - sd_lba = lba, sd_rd = 1.
  - Hold until sd_ack=1, then drop sd_rd, set valid <= 0, go to FILL_XFER.
- FILL_XFER:
  - On sd_buff_wr, buf[sd_buff_addr] <= sd_buff_dout.
  - On sd_ack=0: valid <= 1, cached_lba <= lba, then go to HIT.
- flush_req:
  - If dirty=0 or valid=0: done with err=0 in 2 cycles, no SD traffic.
  - Otherwise: FLUSH_REQ → FLUSH_XFER → DONE.
- DONE state: done=1 and busy=0 for one cycle, then IDLE.
- img_mounted handling:
  - In IDLE or LOOKUP: valid <= 0, dirty <= 0 immediately (dirty data discarded).
  - In HIT: same as IDLE/LOOKUP, and the request completes with err=1.
  - In FLUSH_*/FILL_*: latch mount_pend; complete the current ack handshake (wait for sd_ack=0); then clear valid, dirty and mount_pend, and go to DONE with err=1 (no follow-on fill).
- sd_ack already high on entry to *_REQ: wait for sd_ack=0 first, then for sd_ack=1 (edge-qualified), so a stale ack is never taken as acceptance.
- sd_rd and sd_wr are never both 1.
- sd_lba is stable from *_REQ entry until sd_ack falls.
- Reset mid-transfer: sd_rd/sd_wr drop, and later sd_buff_wr strobes are ignored because writes occur only in FILL_XFER.
- Buffer: a 512x8 dual-port RAM. The SD side writes in FILL_XFER and reads in FLUSH_XFER; the core side is used only in HIT. No port conflicts by construction.

Test Plan:
- Fill path: mount with img_size=1024, byte 0x100 preloaded 0x5A, rd_req addr=0x100 → sd_rd=1 with sd_lba=0; model acks and supplies 512 bytes; rd_data=0x5A, done=1, err=0, sd_rd never rose again after ack.
- Hit timing: rd_req addr=0x101 after the previous fill → done exactly 3 cycles after the request, no sd_rd/sd_wr activity.
- Write-back on miss: wr_req addr=0x010 data 0xA5, then rd_req addr=0x200 → sd_wr with sd_lba=0; byte 16 sampled on sd_buff_din = 0xA5; then sd_rd with sd_lba=1; dirty clear.
- Range and mount errors: rd_req addr=1024 with img_size=1024 → done=1, err=1, rd_data=0xFF, no SD traffic; rd_req before any img_mounted → same.
- Mount mid-fill: img_mounted pulse during FILL_XFER → transfer finishes at sd_ack fall; done=1, err=1; the next rd_req to the same sector refills (sd_rd asserted).
- Reset and contention: rd_req+wr_req in the same cycle → the write is performed; reset asserted during FLUSH_REQ → sd_wr=0 next cycle, busy=0, and a following flush_req gives done in 2 cycles with no SD traffic.

Source files
------------

// File: rtl/sd_sector_cache.sv
// Single-sector write-back cache bridging byte-level disk accesses to the MiST SD block interface.
// One 512-byte buffer with valid/dirty flags; misses flush (if dirty) then fill over the sd_ack handshake.
//
// state      | meaning
// S_IDLE     | waiting for rd/wr/flush request
// S_LOOKUP   | range/mount check, hit/miss decision
// S_HIT      | core-side buffer read or write
// S_FLUSH_REQ| sd_wr raised with cached LBA, waiting for fresh ack
// S_FLUSH_XFER| streaming buffer out until ack falls
// S_FILL_REQ | sd_rd raised with requested LBA, waiting for fresh ack
// S_FILL_XFER| capturing incoming sector until ack falls
// S_DONE     | one-cycle completion pulse
module sd_sector_cache (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_img_mounted,
    input  logic [31:0] i_img_size,
    input  logic        i_rd_req,
    input  logic        i_wr_req,
    input  logic        i_flush_req,
    input  logic [31:0] i_byte_addr,
    input  logic [7:0]  i_wr_data,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_sd_lba,
    output logic        o_sd_rd,
    output logic        o_sd_wr,
    input  logic        i_sd_ack,
    input  logic [8:0]  i_sd_buff_addr,
    input  logic [7:0]  i_sd_buff_dout,
    input  logic        i_sd_buff_wr,
    output logic [7:0]  o_sd_buff_din
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_HIT, S_FLUSH_REQ,
        S_FLUSH_XFER, S_FILL_REQ, S_FILL_XFER, S_DONE
    } state_t;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_FL} op_t;

    state_t      r_state;
    state_t      w_state_nxt;
    op_t         r_op;
    logic [31:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_valid;
    logic        r_dirty;
    logic        r_mounted;
    logic        r_mount_pend;
    logic [31:0] r_cached_lba;
    logic        r_ack_low;
    logic        r_err;
    logic [7:0]  r_rd_data;
    logic [31:0] r_sd_lba;
    logic [7:0]  r_sd_buff_din;
    logic [7:0]  r_mem [0:511];

    logic [31:0] w_lba;
    logic [8:0]  w_off;
    logic        w_valid_eff;
    logic        w_dirty_eff;
    logic        w_mounted_eff;
    logic        w_pend;
    logic        w_hit;
    logic        w_range_err;
    logic        w_ack_take;
    logic        w_req;
    logic        w_core_we;
    logic        w_sd_we;

    assign w_lba         = {9'b0, r_addr[31:9]};
    assign w_off         = r_addr[8:0];
    // A mount pulse landing in LOOKUP must already invalidate the decision it is making.
    assign w_valid_eff   = r_valid & ~i_img_mounted;
    assign w_dirty_eff   = r_dirty & ~i_img_mounted;
    assign w_mounted_eff = r_mounted | i_img_mounted;
    assign w_pend        = r_mount_pend | i_img_mounted;
    assign w_hit         = w_valid_eff && (w_lba == r_cached_lba);
    assign w_range_err   = !w_mounted_eff || (r_addr >= i_img_size);
    // Ack only counts once it has been seen low inside the request state.
    assign w_ack_take    = i_sd_ack && r_ack_low;
    assign w_req         = i_wr_req | i_rd_req | i_flush_req;
    assign w_core_we     = (r_state == S_HIT) && (r_op == OP_WR) && !i_img_mounted && !i_reset;
    assign w_sd_we       = (r_state == S_FILL_XFER) && i_sd_buff_wr && !i_reset;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_state_nxt = S_LOOKUP;
            S_LOOKUP: begin
                if (r_op == OP_FL)
                    w_state_nxt = (w_valid_eff && w_dirty_eff) ? S_FLUSH_REQ : S_DONE;
                else if (w_range_err) w_state_nxt = S_DONE;
                else if (w_hit)       w_state_nxt = S_HIT;
                else if (w_dirty_eff) w_state_nxt = S_FLUSH_REQ;
                else                  w_state_nxt = S_FILL_REQ;
            end
            S_HIT:        w_state_nxt = S_DONE;
            S_FLUSH_REQ:  if (w_ack_take) w_state_nxt = S_FLUSH_XFER;
            S_FLUSH_XFER: if (!i_sd_ack)
                              w_state_nxt = (w_pend || r_op == OP_FL) ? S_DONE : S_FILL_REQ;
            S_FILL_REQ:   if (w_ack_take) w_state_nxt = S_FILL_XFER;
            S_FILL_XFER:  if (!i_sd_ack) w_state_nxt = w_pend ? S_DONE : S_HIT;
            S_DONE:       w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_op          <= OP_RD;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_valid       <= 1'b0;
            r_dirty       <= 1'b0;
            r_mounted     <= 1'b0;
            r_mount_pend  <= 1'b0;
            r_cached_lba  <= '0;
            r_ack_low     <= 1'b0;
            r_err         <= 1'b0;
            r_rd_data     <= '0;
            r_sd_lba      <= '0;
            r_sd_buff_din <= '0;
        end else begin
            if (i_img_mounted) r_mounted <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_img_mounted) begin
                        r_valid <= 1'b0;
                        r_dirty <= 1'b0;
                    end
                    if (r_state == S_IDLE && w_req) begin
                        r_err   <= 1'b0;
                        r_addr  <= i_byte_addr;
                        r_wdata <= i_wr_data;
                        if (i_wr_req)      r_op <= OP_WR;
                        else if (i_rd_req) r_op <= OP_RD;
                        else               r_op <= OP_FL;
                    end
                end
                S_LOOKUP: begin
                    if (i_img_mounted) begin
                        r_valid <= 1'b0;
                        r_dirty <= 1'b0;
                    end
                    if (w_state_nxt == S_DONE && r_op != OP_FL) begin
                        r_err     <= 1'b1;
                        r_rd_data <= 8'hFF;
                    end
                    r_ack_low <= 1'b0;
                    if (w_state_nxt == S_FLUSH_REQ) r_sd_lba <= r_cached_lba;
                    if (w_state_nxt == S_FILL_REQ)  r_sd_lba <= w_lba;
                end
                S_HIT: begin
                    if (i_img_mounted) begin
                        r_valid   <= 1'b0;
                        r_dirty   <= 1'b0;
                        r_err     <= 1'b1;
                        r_rd_data <= 8'hFF;
                    end else if (r_op == OP_RD) begin
                        r_rd_data <= r_mem[w_off];
                    end else begin
                        r_dirty <= 1'b1;
                    end
                end
                S_FLUSH_REQ, S_FILL_REQ: begin
                    if (i_img_mounted) r_mount_pend <= 1'b1;
                    if (!i_sd_ack) r_ack_low <= 1'b1;
                    if (r_state == S_FILL_REQ && w_ack_take) r_valid <= 1'b0;
                end
                S_FLUSH_XFER: begin
                    r_sd_buff_din <= r_mem[i_sd_buff_addr];
                    if (i_img_mounted) r_mount_pend <= 1'b1;
                    if (!i_sd_ack) begin
                        r_dirty <= 1'b0;
                        if (w_pend) begin
                            r_valid      <= 1'b0;
                            r_mount_pend <= 1'b0;
                            r_err        <= 1'b1;
                            r_rd_data    <= 8'hFF;
                        end else if (r_op != OP_FL) begin
                            r_sd_lba  <= w_lba;
                            r_ack_low <= 1'b0;
                        end
                    end
                end
                S_FILL_XFER: begin
                    if (i_img_mounted) r_mount_pend <= 1'b1;
                    if (!i_sd_ack) begin
                        if (w_pend) begin
                            r_valid      <= 1'b0;
                            r_dirty      <= 1'b0;
                            r_mount_pend <= 1'b0;
                            r_err        <= 1'b1;
                            r_rd_data    <= 8'hFF;
                        end else begin
                            r_valid      <= 1'b1;
                            r_cached_lba <= w_lba;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Core port only writes in HIT, SD port only in FILL_XFER, so they never collide.
    always_ff @(posedge i_clk_sys) begin
        if (w_core_we)    r_mem[w_off]          <= r_wdata;
        else if (w_sd_we) r_mem[i_sd_buff_addr] <= i_sd_buff_dout;
    end

    assign o_rd_data     = r_rd_data;
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done        = (r_state == S_DONE);
    assign o_err         = r_err && (r_state == S_DONE);
    assign o_sd_lba      = r_sd_lba;
    assign o_sd_rd       = (r_state == S_FILL_REQ);
    assign o_sd_wr       = (r_state == S_FLUSH_REQ);
    assign o_sd_buff_din = r_sd_buff_din;

endmodule

// File: tb/tb_sd_sector_cache.sv
// Bench for sd_sector_cache: an SD responder backed by a disk array, a scripted vector table,
// hand sequences for mount/reset corners, and random traffic against a flat-memory reference.
module tb_sd_sector_cache;

    localparam int OP_RD = 1;
    localparam int OP_WR = 2;
    localparam int OP_FL = 4;

    logic        clk = 1'b0;
    logic        reset, img_mounted, rd_req, wr_req, flush_req;
    logic [31:0] img_size, byte_addr;
    logic [7:0]  wr_data, rd_data;
    logic        busy, done, err;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  buff_addr;
    logic [7:0]  buff_dout, buff_din;
    logic        buff_wr;

    always #5 clk = ~clk;

    sd_sector_cache dut (
        .i_clk_sys(clk), .i_reset(reset), .i_img_mounted(img_mounted), .i_img_size(img_size),
        .i_rd_req(rd_req), .i_wr_req(wr_req), .i_flush_req(flush_req),
        .i_byte_addr(byte_addr), .i_wr_data(wr_data), .o_rd_data(rd_data),
        .o_busy(busy), .o_done(done), .o_err(err), .o_sd_lba(sd_lba),
        .o_sd_rd(sd_rd), .o_sd_wr(sd_wr), .i_sd_ack(sd_ack),
        .i_sd_buff_addr(buff_addr), .i_sd_buff_dout(buff_dout),
        .i_sd_buff_wr(buff_wr), .o_sd_buff_din(buff_din)
    );

    int          n_err = 0;
    int          n_chk = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_lba = '0;
    logic [31:0] last_wr_lba = '0;
    logic        excl_bad = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic        resp_en = 1'b1;
    logic        t_wr;
    int          t_base;
    logic [7:0]  disk [0:4095];
    logic [7:0]  lm [0:2047];

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Counts sector requests as they are raised and remembers their LBA.
    initial begin
        forever begin
            @(negedge clk);
            if (sd_rd && !prev_rd) begin rd_cnt++; last_rd_lba = sd_lba; end
            if (sd_wr && !prev_wr) begin wr_cnt++; last_wr_lba = sd_lba; end
            if (sd_rd && sd_wr) excl_bad = 1'b1;
            prev_rd = sd_rd;
            prev_wr = sd_wr;
        end
    end

    // SD side: the disk image lives here; sectors stream one byte per cycle.
    initial begin
        sd_ack = 1'b0; buff_addr = '0; buff_dout = '0; buff_wr = 1'b0;
        for (int i = 0; i < 4096; i++) disk[i] = pat(i);
        disk[256] = 8'h5A;
        forever begin
            @(negedge clk);
            if (resp_en && (sd_rd || sd_wr)) begin
                t_wr   = sd_wr;
                t_base = int'(sd_lba[2:0]) * 512;
                repeat (2) @(negedge clk);
                sd_ack = 1'b1;
                if (!t_wr) begin
                    for (int i = 0; i < 512; i++) begin
                        @(negedge clk);
                        buff_addr = 9'(i); buff_dout = disk[t_base + i]; buff_wr = 1'b1;
                    end
                    @(negedge clk);
                    buff_wr = 1'b0;
                end else begin
                    for (int i = 0; i <= 512; i++) begin
                        @(negedge clk);
                        if (i > 0) disk[t_base + i - 1] = buff_din;
                        if (i < 512) buff_addr = 9'(i);
                    end
                    @(negedge clk);
                end
                sd_ack = 1'b0;
            end
        end
    end

    task automatic do_op(input int op, input logic [31:0] a, input logic [7:0] d,
                         output logic [7:0] rdv, output logic erv, output int lat,
                         output int nrd, output int nwr);
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clk);
        byte_addr = a; wr_data = d;
        rd_req = op[0]; wr_req = op[1]; flush_req = op[2];
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                rd_req = 1'b0; wr_req = 1'b0; flush_req = 1'b0;
                chk("busy_after_accept", busy, 1);
            end
            if (done) break;
            if (lat > 4000) begin
                n_chk++; n_err++;
                $display("FAIL op_timeout: done=0 after %0d cycles, required done=1", lat);
                break;
            end
        end
        rdv = rd_data; erv = err; nrd = rd_cnt - r0; nwr = wr_cnt - w0;
    endtask

    task automatic mount(input logic [31:0] sz);
        @(negedge clk);
        img_size = sz; img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
    endtask

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic [7:0]  erd;
        logic        chk_rd;
        logic        eerr;
        int          elat;
        int          enrd;
        int          enwr;
        logic [31:0] rlba;
        logic [31:0] wlba;
    } vec_t;

    vec_t        tv [12];
    logic [7:0]  rdv;
    logic        erv;
    int          lat, nrd, nwr, cyc, r0;
    int          rop, mis;
    logic [31:0] ra;
    logic [7:0]  rwd;
    logic        mv, md;
    int          ml, lba;

    initial begin
        reset = 1'b1; img_mounted = 1'b0; img_size = 32'd1024;
        rd_req = 1'b0; wr_req = 1'b0; flush_req = 1'b0; byte_addr = '0; wr_data = '0;

        tv[0]  = '{OP_RD, 32'h100, 8'h00, 8'h5A,      1'b1, 1'b0, -1, 1, 0, 0, 0};
        tv[1]  = '{OP_RD, 32'h101, 8'h00, pat(32'h101), 1'b1, 1'b0, 3, 0, 0, 0, 0};
        tv[2]  = '{OP_WR, 32'h010, 8'hA5, 8'h00,      1'b0, 1'b0, 3, 0, 0, 0, 0};
        tv[3]  = '{OP_RD, 32'h010, 8'h00, 8'hA5,      1'b1, 1'b0, 3, 0, 0, 0, 0};
        tv[4]  = '{OP_RD, 32'h200, 8'h00, pat(32'h200), 1'b1, 1'b0, -1, 1, 1, 1, 0};
        tv[5]  = '{OP_RD, 32'd1024, 8'h00, 8'hFF,     1'b1, 1'b1, -1, 0, 0, 0, 0};
        tv[6]  = '{OP_RD, 32'hFFFF_FFF0, 8'h00, 8'hFF, 1'b1, 1'b1, -1, 0, 0, 0, 0};
        tv[7]  = '{OP_FL, 32'h0, 8'h00, 8'h00,        1'b0, 1'b0, 2, 0, 0, 0, 0};
        tv[8]  = '{OP_WR, 32'h3FF, 8'h77, 8'h00,      1'b0, 1'b0, 3, 0, 0, 0, 0};
        tv[9]  = '{OP_FL, 32'h0, 8'h00, 8'h00,        1'b0, 1'b0, -1, 0, 1, 0, 1};
        tv[10] = '{OP_RD, 32'h3FF, 8'h00, 8'h77,      1'b1, 1'b0, 3, 0, 0, 0, 0};
        tv[11] = '{OP_RD, 32'h1FF, 8'h00, pat(32'h1FF), 1'b1, 1'b0, -1, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {rd_data, busy, done, err, sd_rd, sd_wr, buff_din}, 0);
        chk("reset_sd_lba", sd_lba, 0);
        reset = 1'b0;

        do_op(OP_RD, 32'h100, 8'h00, rdv, erv, lat, nrd, nwr);
        chk("nomount_err", erv, 1);
        chk("nomount_rd", rdv, 8'hFF);
        chk("nomount_traffic", nrd + nwr, 0);

        mount(32'd1024);
        for (int k = 0; k < 12; k++) begin
            do_op(tv[k].op, tv[k].addr, tv[k].wd, rdv, erv, lat, nrd, nwr);
            if (tv[k].chk_rd) chk($sformatf("vec%0d_rd", k), rdv, tv[k].erd);
            chk($sformatf("vec%0d_err", k), erv, tv[k].eerr);
            if (tv[k].elat >= 0) chk($sformatf("vec%0d_lat", k), lat, tv[k].elat);
            chk($sformatf("vec%0d_nrd", k), nrd, tv[k].enrd);
            chk($sformatf("vec%0d_nwr", k), nwr, tv[k].enwr);
            if (tv[k].enrd > 0) chk($sformatf("vec%0d_rd_lba", k), last_rd_lba, tv[k].rlba);
            if (tv[k].enwr > 0) chk($sformatf("vec%0d_wr_lba", k), last_wr_lba, tv[k].wlba);
        end
        chk("wb_byte16", disk[16], 8'hA5);
        chk("wb_byte3ff", disk[32'h3FF], 8'h77);

        // Simultaneous read and write: the write wins.
        do_op(OP_RD | OP_WR, 32'h0FE, 8'h3C, rdv, erv, lat, nrd, nwr);
        chk("contend_traffic", nrd + nwr, 0);
        do_op(OP_RD, 32'h0FE, 8'h00, rdv, erv, lat, nrd, nwr);
        chk("contend_rd", rdv, 8'h3C);
        do_op(OP_FL, 32'h0, 8'h00, rdv, erv, lat, nrd, nwr);
        chk("contend_flush_nwr", nwr, 1);

        // Mount pulse in the middle of a fill.
        r0 = rd_cnt;
        @(negedge clk); byte_addr = 32'h200; rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        cyc = 0;
        while (!sd_ack && cyc < 200) begin @(negedge clk); cyc++; end
        chk("midfill_ack_seen", sd_ack, 1);
        repeat (20) @(negedge clk);
        img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("midfill_done", done, 1);
        chk("midfill_err", err, 1);
        chk("midfill_ack_low", sd_ack, 0);
        chk("midfill_nrd", rd_cnt - r0, 1);
        do_op(OP_RD, 32'h200, 8'h00, rdv, erv, lat, nrd, nwr);
        chk("refill_nrd", nrd, 1);
        chk("refill_rd", rdv, pat(32'h200));
        chk("refill_err", erv, 0);

        // Reset while a write-back request is pending.
        do_op(OP_WR, 32'h205, 8'h11, rdv, erv, lat, nrd, nwr);
        chk("dirty_hit_traffic", nrd + nwr, 0);
        resp_en = 1'b0;
        @(negedge clk); byte_addr = 32'h000; rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        cyc = 0;
        while (!sd_wr && cyc < 50) begin @(negedge clk); cyc++; end
        chk("abort_sd_wr_raised", sd_wr, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sd_wr_drop", sd_wr, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b0;
        do_op(OP_FL, 32'h0, 8'h00, rdv, erv, lat, nrd, nwr);
        chk("abort_flush_lat", lat, 2);
        chk("abort_flush_err", erv, 0);
        chk("abort_flush_traffic", nrd + nwr, 0);
        resp_en = 1'b1;

        // Random traffic: reads must always return the latest written byte.
        mount(32'd4096);
        for (int i = 0; i < 2048; i++) lm[i] = disk[i];
        mv = 1'b0; md = 1'b0; ml = 0;
        for (int it = 0; it < 30; it++) begin
            rop = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) ra = 32'd4096 + 32'($urandom_range(0, 2000));
            else ra = 32'($urandom_range(0, 3) * 512 + $urandom_range(0, 511));
            rwd = 8'($urandom);
            if (rop == 0) begin
                do_op(OP_FL, ra, rwd, rdv, erv, lat, nrd, nwr);
                chk("rnd_fl_err", erv, 0);
                chk("rnd_fl_nrd", nrd, 0);
                chk("rnd_fl_nwr", nwr, (mv && md) ? 1 : 0);
                md = 1'b0;
            end else begin
                do_op((rop < 5) ? OP_RD : OP_WR, ra, rwd, rdv, erv, lat, nrd, nwr);
                if (ra >= 32'd4096) begin
                    chk("rnd_oob_err", erv, 1);
                    chk("rnd_oob_rd", rdv, 8'hFF);
                    chk("rnd_oob_traffic", nrd + nwr, 0);
                end else begin
                    lba = int'(ra) / 512;
                    chk("rnd_err", erv, 0);
                    if (mv && lba == ml) begin
                        chk("rnd_hit_traffic", nrd + nwr, 0);
                        chk("rnd_hit_lat", lat, 3);
                    end else begin
                        chk("rnd_miss_nrd", nrd, 1);
                        chk("rnd_miss_nwr", nwr, (mv && md) ? 1 : 0);
                        mv = 1'b1; md = 1'b0; ml = lba;
                    end
                    if (rop < 5) chk($sformatf("rnd_rd_%0h", ra), rdv, lm[int'(ra)]);
                    else begin md = 1'b1; lm[int'(ra)] = rwd; end
                end
            end
        end
        do_op(OP_FL, 32'h0, 8'h00, rdv, erv, lat, nrd, nwr);
        chk("final_flush_nwr", nwr, (mv && md) ? 1 : 0);
        mis = 0;
        for (int i = 0; i < 2048; i++) if (disk[i] !== lm[i]) mis++;
        chk("disk_vs_model_mismatches", mis, 0);
        chk("rd_wr_exclusive", excl_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
